// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   FIFO of committed stores sitting between the MEM stage and a
//   byte-addressed data memory. Stores enter in one cycle and retire to
//   memory later, only when no load needs the memory port, or when a fence
//   (i_Drain) or a load/store overlap forces the buffer to drain.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   i_St_*          store request (valid, byte address, data, funct3)
//   o_St_Ready      buffer not full; a store may be accepted this cycle
//   i_Ld_*          load issued by MEM stage (valid, byte address, funct3)
//   o_Ld_Conflict   load byte span overlaps a pending store; hold the load
//   i_Drain         fence: retire entries regardless of load traffic
//   o_Empty         no pending stores
//   o_WE/o_A/o_WD/o_Funct3  memory write port, driven from the head entry
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int Address_Width = 32,
    parameter int Word_Width    = 32,
    parameter int SB_Depth      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_St_Valid,
    input  logic [Address_Width-1:0] i_St_A,
    input  logic [Word_Width-1:0]    i_St_WD,
    input  logic [2:0]               i_St_Funct3,
    output logic                     o_St_Ready,
    input  logic                     i_Ld_Valid,
    input  logic [Address_Width-1:0] i_Ld_A,
    input  logic [2:0]               i_Ld_Funct3,
    output logic                     o_Ld_Conflict,
    input  logic                     i_Drain,
    output logic                     o_Empty,
    output logic                     o_WE,
    output logic [Address_Width-1:0] o_A,
    output logic [Word_Width-1:0]    o_WD,
    output logic [2:0]               o_Funct3
);

    localparam int PTR_W = (SB_Depth > 1) ? $clog2(SB_Depth) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SPN_W = Address_Width + 1;

    // Entry storage
    logic [Address_Width-1:0] a_q  [SB_Depth];
    logic [Word_Width-1:0]    wd_q [SB_Depth];
    logic [2:0]               f3_q [SB_Depth];
    logic [SB_Depth-1:0]      vld_q, vld_d;

    // Pointers and occupancy
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic push;
    logic pop;

    // Span length minus one for a store: SH -> 1, SW -> 3, anything else is a byte.
    function automatic logic [2:0] st_len_m1(input logic [2:0] f3);
        case (f3)
            3'b001:  st_len_m1 = 3'd1;
            3'b010:  st_len_m1 = 3'd3;
            default: st_len_m1 = 3'd0;
        endcase
    endfunction

    // Span length minus one for a load: LH/LHU -> 1, LW -> 3, anything else is a byte.
    function automatic logic [2:0] ld_len_m1(input logic [2:0] f3);
        case (f3)
            3'b001, 3'b101: ld_len_m1 = 3'd1;
            3'b010:         ld_len_m1 = 3'd3;
            default:        ld_len_m1 = 3'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Occupancy flags
    // ------------------------------------------------------------------
    always_comb begin
        full       = (count_q == CNT_W'(SB_Depth));
        o_Empty    = (count_q == '0);
        // Readiness depends on the registered count only; a pop in the same
        // cycle never frees a slot for a simultaneous push.
        o_St_Ready = !full;
        push       = i_St_Valid && !full;
    end

    // ------------------------------------------------------------------
    // Load conflict detection
    //   Spans are compared one bit wider than the address so that an access
    //   at the top of the address space does not wrap onto address 0.
    // ------------------------------------------------------------------
    logic [SPN_W-1:0]    ld_lo, ld_hi;
    logic [SB_Depth-1:0] hit;

    always_comb begin
        ld_lo = {1'b0, i_Ld_A};
        ld_hi = ld_lo + {{(SPN_W-3){1'b0}}, ld_len_m1(i_Ld_Funct3)};
    end

    for (genvar g = 0; g < SB_Depth; g++) begin : g_hit
        logic [SPN_W-1:0] st_lo, st_hi;
        always_comb begin
            st_lo    = {1'b0, a_q[g]};
            st_hi    = st_lo + {{(SPN_W-3){1'b0}}, st_len_m1(f3_q[g])};
            hit[g]   = vld_q[g] && (st_lo <= ld_hi) && (ld_lo <= st_hi);
        end
    end

    // Only registered entries are examined, so a store accepted this very
    // cycle can never flag the load issued alongside it.
    always_comb begin
        o_Ld_Conflict = i_Ld_Valid && (|hit);
    end

    // ------------------------------------------------------------------
    // Memory write port (head entry, combinational)
    // ------------------------------------------------------------------
    always_comb begin
        o_WE = !o_Empty && (!i_Ld_Valid || o_Ld_Conflict || i_Drain);
        pop  = o_WE;
        if (o_Empty) begin
            o_A      = '0;
            o_WD     = '0;
            o_Funct3 = '0;
        end else begin
            o_A      = a_q[head_q];
            o_WD     = wd_q[head_q];
            o_Funct3 = f3_q[head_q];
        end
    end

    // ------------------------------------------------------------------
    // Next-state for pointers, count and valid bits
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        vld_d   = vld_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        // Clearing before setting is safe: when full no push happens, and
        // when not full head and tail cannot alias a live slot being pushed.
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload needs no reset: it is only observed through valid bits
    // and the empty-gated output mux.
    always_ff @(posedge clk) begin
        if (push) begin
            a_q[tail_q]  <= i_St_A;
            wd_q[tail_q] <= i_St_WD;
            f3_q[tail_q] <= i_St_Funct3;
        end
    end

endmodule
